// File: rtl/move_scheduler.sv
// Frame-synchronous movement scheduler: round-robin button arbitration, one command per step slot.
// Optional acceleration enabled by defining MOVE_SCHED_ACCEL_EN.
//   state | meaning
//   IDLE  | no command pending, waiting for a step slot
//   ISSUE | command held on step_valid until the datapath accepts it
module move_scheduler #(
    parameter logic [9:0]  FRAME_V         = 10'd516,
    parameter int unsigned FRAMES_PER_STEP = 2,
    parameter int unsigned ACCEL_STEPS     = 8,
    parameter logic [2:0]  FAST_SIZE       = 3'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] step_dir,
    output logic [2:0] step_size,
    output logic       missed
);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t     state;
    logic       cmp_q;
    logic       cmp_d;
    logic [3:0] frame_cnt;
    logic [1:0] last_grant;
    logic       frame_pulse;
    logic       slot;
    logic [3:0] req;
    logic [1:0] grant;
    logic [1:0] idx;
    logic       found;

    // Rising edge of the registered compare keeps the pulse one cycle wide for any pixel-clock ratio.
    assign frame_pulse = cmp_q & ~cmp_d;
    assign slot        = frame_pulse && (frame_cnt == 4'(FRAMES_PER_STEP - 1));

    assign req[1:0] = (left & right) ? 2'b00 : {left, right};
    assign req[3:2] = (up & down)    ? 2'b00 : {down, up};

    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

`ifdef MOVE_SCHED_ACCEL_EN
    logic [7:0] hold_cnt;
    logic [1:0] prev_dir;
    logic [2:0] size_next;

    assign size_next = (hold_cnt == 8'(ACCEL_STEPS) && grant == prev_dir) ? FAST_SIZE : 3'd1;
`else
    assign step_size = 3'd1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmp_q      <= 1'b0;
            cmp_d      <= 1'b0;
            frame_cnt  <= 4'd0;
            last_grant <= 2'd3;
            step_valid <= 1'b0;
            step_dir   <= 2'd0;
            missed     <= 1'b0;
`ifdef MOVE_SCHED_ACCEL_EN
            step_size  <= 3'd1;
            hold_cnt   <= 8'd0;
            prev_dir   <= 2'd0;
`endif
        end else begin
            cmp_q <= (vCount == FRAME_V) && (hCount == 10'd0);
            cmp_d <= cmp_q;
            if (frame_pulse)
                frame_cnt <= slot ? 4'd0 : frame_cnt + 4'd1;

            case (state)
                IDLE: begin
                    if (slot) begin
                        if (|req) begin
                            step_valid <= 1'b1;
                            step_dir   <= grant;
                            last_grant <= grant;
`ifdef MOVE_SCHED_ACCEL_EN
                            step_size  <= size_next;
`endif
                            state      <= ISSUE;
                        end else begin
`ifdef MOVE_SCHED_ACCEL_EN
                            hold_cnt <= 8'd0;
`endif
                        end
                    end
                end
                ISSUE: begin
                    // A transfer in the slot cycle wins: no miss flagged and that slot is consumed.
                    if (step_ready) begin
                        step_valid <= 1'b0;
                        state      <= IDLE;
`ifdef MOVE_SCHED_ACCEL_EN
                        if (hold_cnt != 8'd0 && step_dir == prev_dir)
                            hold_cnt <= (hold_cnt == 8'(ACCEL_STEPS)) ? hold_cnt : hold_cnt + 8'd1;
                        else
                            hold_cnt <= 8'd1;
                        prev_dir <= step_dir;
`endif
                    end else if (slot) begin
                        missed <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Frame-synchronous movement scheduler for the on-screen block. It samples the debounced direction buttons once per N video frames and arbitrates simultaneous presses round-robin. It issues one movement command per step slot over a valid/ready handshake to the position datapath, so that position updates occur during vertical blanking instead of on a free-running slow clock. An optional acceleration feature raises the step size after a direction has been held for a number of consecutive steps.

## Interface
- FRAME_V, 10'd516: vCount line that marks a frame boundary (first blanking line after the display area).
- FRAMES_PER_STEP, 2: frame boundaries per step slot; legal range 1..15.
- ACCEL_STEPS, 8: consecutive same-direction accepted steps before fast mode; legal range 1..255.
- FAST_SIZE, 3'd4: step size in fast mode.
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- up, down, left, right  in  1 each  debounced button levels, synchronous to clk.
- hCount, vCount  in  10 each  raster counters from the display controller.
- step_ready  in  1  datapath can accept a command this cycle.
- step_valid  out  1  command pending.
- step_dir  out  2  0=right, 1=left, 2=up, 3=down; stable while step_valid is high.
- step_size  out  3  pixels to move; stable while step_valid is high.
- missed  out  1  sticky: a step slot arrived while a command was still pending.

## Operation
- Reset values:
  - step_valid=0, step_dir=0, step_size=1, missed=0.
  - Internal: frame_cnt=0, last_grant=3, hold_cnt=0, state=IDLE.
- Frame detect: compare (vCount==FRAME_V && hCount==0) is registered. frame_pulse is its rising edge, exactly 1 cycle wide per frame regardless of pixel-clock ratio.
- Slot: on frame_pulse, if frame_cnt==FRAMES_PER_STEP-1 then frame_cnt<=0 and the slot fires; else frame_cnt<=frame_cnt+1.
- Request vector: {down,up,left,right}. If left and right are both high, both are masked. The same applies to up and down.
- Arbitration: grant = first set request searching from (last_grant+1) mod 4 upward with wrap. last_grant updates only on issue. After reset, right has priority.
- States:
  - IDLE: slot fires with nonzero masked request → load step_dir=grant and step_size, assert step_valid, go to ISSUE. Slot fires with zero request → hold_cnt<=0, stay.
  - ISSUE: step_valid && step_ready → step_valid<=0, update accel counter, go to IDLE. Slot fires while in ISSUE → missed<=1, command retained unchanged, no new grant.
- Accel counter:
  - On an accepted step equal to the previous accepted direction, hold_cnt<=min(hold_cnt+1, ACCEL_STEPS).
  - On an accepted step in a different direction, hold_cnt<=1.
- step_size at issue: FAST_SIZE if hold_cnt==ACCEL_STEPS and grant equals the previous accepted direction, else 1.
- missed clears only on rst.

## Timing
- step_valid rises 2 cycles after the first clk edge at which the frame-boundary compare is true: 1 cycle for the compare register, 1 for issue.
- Handshake: a transfer occurs on the edge where step_valid && step_ready. step_valid is low the following cycle. step_ready may be held high permanently, giving a 1-cycle valid pulse.
- Buttons are sampled only in the slot-fire cycle. Presses shorter than a slot are ignored.
- Simultaneous transfer and slot fire in ISSUE: the transfer completes, missed is not set, and no new command issues for that slot.
- rst mid-ISSUE: step_valid is 0 after the next edge, and the pending command is discarded.
- frame_cnt and hold_cnt saturate or wrap only as stated. No arithmetic overflow is reachable within the legal parameter ranges.

## Configuration
- MOVE_SCHED_ACCEL_EN defined: hold_cnt logic present; step_size follows the acceleration rule above.
- MOVE_SCHED_ACCEL_EN undefined: no hold_cnt register is synthesized; step_size is constant 3'd1, including at reset.

## Test plan
- Reset, FRAMES_PER_STEP=2, step_ready=1, right held across 4 frame boundaries → exactly 2 one-cycle step_valid pulses with dir=0, size=1, each 2 cycles after the second boundary of its slot.
- up and right held together, 4 slots → dir sequence 0,2,0,2; left+right held with nothing else → no step_valid and hold_cnt cleared.
- step_ready=0 across 2 slots → step_valid stays high with dir/size unchanged, missed=1. Then step_ready=1 → one transfer, missed remains 1.
- Accel enabled, ACCEL_STEPS=3, FAST_SIZE=4, down held → sizes 1,1,1,4,4. Switch to left → size 1. Release all for one slot, then press down → size 1.
- Accel disabled build → same stimulus gives size 1 on every step.
- Assert rst while step_valid=1 → step_valid=0, missed=0, and the next grant with all buttons held is right.
